timer_cmp: RTL and testbench
============================

Name: timer_cmp

Overview:
- Bus-writable compare timer on the peripheral bus, clocked by clk_bus.
- Counterpart to the read-only tick counter: software writes count, compare value and control; the block counts and drives an interrupt request to the CPU.
- Single clock domain, so no synchronisers.
- Read data returns in the same cycle, gated by bus_read.

Parameters:
- WIDTH, 32, counter/compare width; must be ≤32; bus reads zero-extend, bus writes truncate to WIDTH.

Ports:
- clk_bus  input  1  bus clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- bus_data_o  output  32  read data; register value when bus_read=1, else 32'd0
- bus_address  input  8  byte address; [4:2] selects the register, [1:0] ignored, [7:5] must be 0
- bus_data_i  input  32  write data
- bus_read  input  1  read strobe; combinational read, no side effects
- bus_write  input  1  write strobe; one write per cycle while high
- irq  output  1  interrupt request, level, = pending & ctrl.ie

Behaviour:
- Register map (word offset):
  - 0x00 COUNT, RW
  - 0x04 COMPARE, RW
  - 0x08 CTRL, RW: bit0 en, bit1 autoreload, bit2 ie; others read 0
  - 0x0C STATUS: bit0 pending; write 1 clears; others read 0
  - 0x10 PRESCALE: see optional feature
- Unmapped addresses (including [7:5]≠0) read 0; writes to them are ignored.
- Reset (async, rst_n=0): COUNT=0, COMPARE={WIDTH{1}}, CTRL=0, pending=0, prescale state=0, irq=0. bus_data_o is still 0 unless bus_read=1.
- Tick: a cycle in which en=1 and the prescaler has expired. Without the prescaler feature, every cycle with en=1 is a tick.
- On a tick:
  - If COUNT==COMPARE: set pending. COUNT<=0 if autoreload=1, else COUNT<=COUNT+1.
  - Otherwise: COUNT<=COUNT+1.
  - Increment wraps modulo 2^WIDTH; the wrap itself raises no flag.
- Match is evaluated on the pre-update COUNT. Pending rises on the clock edge after the cycle in which COUNT==COMPARE was held across a tick. irq follows pending combinationally.
- en=0: COUNT holds, no match is evaluated, pending holds.
- Priority when events coincide:
  - Bus write to COUNT beats the tick increment; the written value is loaded and no match is evaluated that cycle.
  - Bus write to COMPARE takes effect the next cycle; the match in the same cycle uses the old COMPARE.
  - STATUS write-1-clear and a match in the same cycle: set wins, pending=1.
  - CTRL write: takes effect the next cycle. The current-cycle tick uses the old en.
- Reads are purely combinational. A read in the same cycle as a write returns the pre-write value.
- Asserting reset mid-count returns every register to its reset value immediately. Counting resumes only after software sets en.

Optional Feature:
- Macro: TIMER_CMP_PRESCALER_EN.
- Defined:
  - 0x10 PRESCALE is an RW 16-bit register, reset 0.
  - An internal 16-bit divider counts en-cycles. A tick occurs when divider==PRESCALE; the divider then resets to 0, otherwise it increments.
  - Ticks therefore occur every PRESCALE+1 enabled cycles.
  - A write to PRESCALE or COUNT resets the divider to 0.
  - en=0 holds the divider.
- Undefined:
  - No divider logic is built; every en cycle is a tick.
  - 0x10 reads 0 and writes to it are ignored.

Test Plan:
- Reset values: release rst_n, read 0x00/0x04/0x08/0x0C → 0, 0xFFFFFFFF, 0, 0; irq=0; bus_data_o=0 with bus_read=0.
- Match without autoreload:
  - Stimulus: COMPARE=5, CTRL=0x5, then wait.
  - pending and irq rise on the edge after COUNT==5 is sampled.
  - COUNT continues 6, 7, …
  - Write 0x1 to STATUS → irq drops next cycle.
- Autoreload and wrap:
  - CTRL=0x7, COMPARE=3 → COUNT cycles 0,1,2,3,0; pending set on each 3→0 transition.
  - Separately: COUNT=0xFFFFFFFF, COMPARE=10, en=1 → COUNT reads 0 the next cycle, pending stays 0.
- Collisions:
  - Write COUNT=100 in the cycle COUNT==COMPARE → COUNT=100, pending unchanged.
  - W1C STATUS in a match cycle → pending=1.
- Enable and reset mid-operation:
  - Clear en at COUNT=7 → COUNT holds 7 for 10 cycles.
  - Assert rst_n low mid-count → all registers at reset values with no clock edge required.
- Prescaler (macro defined):
  - PRESCALE=3, CTRL=0x1 → COUNT increments once every 4 cycles.
  - Reading 0x10 returns 3.
  - Macro undefined: 0x10 reads 0 after writing 3.

Source files
------------

// File: rtl/timer_cmp.sv
// timer_cmp: bus-writable compare timer with level interrupt.
// COUNT advances on every tick; a tick while COUNT==COMPARE sets the pending
// flag, and optionally reloads COUNT to zero. irq = pending & ie.
// Optional prescaler: define TIMER_CMP_PRESCALER_EN to build the 16-bit
// divider and the PRESCALE register at offset 0x10.
module timer_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  output logic [31:0] bus_data_o,
  input  logic [7:0]  bus_address,
  input  logic [31:0] bus_data_i,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        irq
);

  typedef enum logic [2:0] {
    REG_COUNT    = 3'd0,
    REG_COMPARE  = 3'd1,
    REG_CTRL     = 3'd2,
    REG_STATUS   = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  logic             en_q, en_d;
  logic             ar_q, ar_d;
  logic             ie_q, ie_d;
  logic             pending_q, pending_d;

  logic             addr_ok;
  logic [2:0]       reg_sel;
  logic [WIDTH-1:0] wdata;
  logic             wr_count, wr_compare, wr_ctrl, wr_status;
  logic             tick, match;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign addr_ok    = (bus_address[7:5] == 3'd0);
  assign reg_sel    = bus_address[4:2];
  assign wdata      = bus_data_i[WIDTH-1:0];
  assign wr_count   = bus_write && addr_ok && (reg_sel == REG_COUNT);
  assign wr_compare = bus_write && addr_ok && (reg_sel == REG_COMPARE);
  assign wr_ctrl    = bus_write && addr_ok && (reg_sel == REG_CTRL);
  assign wr_status  = bus_write && addr_ok && (reg_sel == REG_STATUS);
  assign unused_bits = ^{bus_address[1:0], bus_data_i};

`ifdef TIMER_CMP_PRESCALER_EN
  logic        wr_prescale;
  logic [15:0] presc_q, presc_d;
  logic [15:0] div_q, div_d;

  assign wr_prescale = bus_write && addr_ok && (reg_sel == REG_PRESCALE);
  assign tick        = en_q && (div_q == presc_q);

  // Divider counts enabled cycles; restarts on expiry or any COUNT/PRESCALE write
  always_comb begin
    presc_d = presc_q;
    div_d   = div_q;
    if (wr_prescale) presc_d = bus_data_i[15:0];
    if (wr_prescale || wr_count) begin
      div_d = '0;
    end else if (en_q) begin
      div_d = (div_q == presc_q) ? '0 : div_q + 16'd1;
    end
  end

  // Prescaler state register
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      div_q   <= '0;
    end else begin
      presc_q <= presc_d;
      div_q   <= div_d;
    end
  end
`else
  assign tick = en_q;
`endif

  // A COUNT write suppresses the match for its cycle
  assign match = tick && !wr_count && (count_q == compare_q);

  // Next-state for counter, compare, control and pending flag
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    en_d      = en_q;
    ar_d      = ar_q;
    ie_d      = ie_q;
    pending_d = pending_q;

    if (wr_count) begin
      count_d = wdata;
    end else if (tick) begin
      count_d = (match && ar_q) ? '0 : count_q + WIDTH'(1);
    end

    if (wr_compare) compare_d = wdata;

    if (wr_ctrl) begin
      en_d = bus_data_i[0];
      ar_d = bus_data_i[1];
      ie_d = bus_data_i[2];
    end

    // set beats write-1-clear
    if (match) begin
      pending_d = 1'b1;
    end else if (wr_status && bus_data_i[0]) begin
      pending_d = 1'b0;
    end
  end

  // Register state
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '1;
      en_q      <= 1'b0;
      ar_q      <= 1'b0;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      en_q      <= en_d;
      ar_q      <= ar_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
    end
  end

  // Combinational read mux, zero-extended, gated by bus_read
  always_comb begin
    rdata = '0;
    if (bus_read && addr_ok) begin
      case (reg_sel)
        REG_COUNT:   rdata[WIDTH-1:0] = count_q;
        REG_COMPARE: rdata[WIDTH-1:0] = compare_q;
        REG_CTRL:    rdata[2:0]       = {ie_q, ar_q, en_q};
        REG_STATUS:  rdata[0]         = pending_q;
`ifdef TIMER_CMP_PRESCALER_EN
        REG_PRESCALE: rdata[15:0]     = presc_q;
`endif
        default:     rdata = '0;
      endcase
    end
  end

  assign bus_data_o = rdata;
  assign irq        = pending_q && ie_q;

endmodule

// File: tb/tb_timer_cmp.sv
// Self-checking bench for timer_cmp: directed scenarios plus a randomized
// run, all checked against a register-level behavioural model.
module tb_timer_cmp;

  logic        clk_bus = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_data_o;
  logic [7:0]  bus_address = '0;
  logic [31:0] bus_data_i = '0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic        irq;

  int nchecks = 0;
  int nfail = 0;

  timer_cmp #(.WIDTH(32)) dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .bus_data_o(bus_data_o),
    .bus_address(bus_address), .bus_data_i(bus_data_i),
    .bus_read(bus_read), .bus_write(bus_write), .irq(irq)
  );

  always #5 clk_bus = ~clk_bus;

  // Reference model: register contents after each clock edge
  logic [31:0] m_count, m_compare;
  logic        m_en, m_ar, m_ie, m_pend;
  logic [15:0] m_presc, m_div;

  task automatic model_reset();
    m_count = 0; m_compare = 32'hFFFF_FFFF;
    m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0;
    m_presc = 0; m_div = 0;
  endtask

  task automatic model_step(input bit we, input logic [7:0] a, input logic [31:0] d);
    int idx;
    bit tk, hit;
    idx = (we && a[7:5] == 3'd0) ? int'(a[4:2]) : -1;
    tk = m_en;
`ifdef TIMER_CMP_PRESCALER_EN
    tk = m_en && (m_div == m_presc);
    if (idx == 0 || idx == 4) m_div = 0;
    else if (m_en) m_div = (m_div == m_presc) ? 16'd0 : 16'(m_div + 1);
`endif
    hit = tk && (idx != 0) && (m_count == m_compare);
    if (idx == 0) m_count = d;
    else if (tk) m_count = (hit && m_ar) ? 32'd0 : m_count + 32'd1;
    if (hit) m_pend = 1;
    else if (idx == 3 && d[0]) m_pend = 0;
    case (idx)
      1: m_compare = d;
      2: begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
`ifdef TIMER_CMP_PRESCALER_EN
      4: m_presc = d[15:0];
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a[7:5] != 3'd0) return 32'd0;
    case (a[4:2])
      3'd0: return m_count;
      3'd1: return m_compare;
      3'd2: return {29'd0, m_ie, m_ar, m_en};
      3'd3: return {31'd0, m_pend};
`ifdef TIMER_CMP_PRESCALER_EN
      3'd4: return {16'd0, m_presc};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, clock edge, update model
  task automatic cycle(input bit we, input logic [7:0] a, input logic [31:0] d);
    bus_write = we; bus_address = a; bus_data_i = d;
    @(posedge clk_bus);
    model_step(we, a, d);
    #1;
    bus_write = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    bus_read = 1; bus_address = a;
    #1;
    v = bus_data_o;
    bus_read = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; bus_write = 0; bus_read = 0;
    model_reset();
    repeat (2) @(posedge clk_bus);
    @(negedge clk_bus);
    rst_n = 1;
    @(posedge clk_bus);
    model_step(0, 8'h00, 32'd0);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd0; exp_v[1] = 32'hFFFF_FFFF; exp_v[2] = 32'd0; exp_v[3] = 32'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(8'(i * 4), v);
      nchecks++;
      if (v !== exp_v[i]) begin
        nfail++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, v, exp_v[i]);
      end
    end
    nchecks++;
    if (irq !== 1'b0) begin nfail++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_address = 8'h04; #1;
    nchecks++;
    if (bus_data_o !== 32'd0) begin
      nfail++; $display("FAIL reset_idle_data got=%h exp=0", bus_data_o);
    end
  endtask

  task automatic test_match();
    logic [31:0] v;
    int guard;
    do_reset();
    cycle(1, 8'h04, 32'd5);
    cycle(1, 8'h08, 32'h5);
    guard = 0;
    while (irq !== 1'b1 && guard < 30) begin
      rd(8'h00, v);
      nchecks++;
      if (v !== m_count) begin nfail++; $display("FAIL match_count got=%0d exp=%0d", v, m_count); end
      cycle(0, 8'h00, 32'd0);
      guard++;
    end
    nchecks++;
    if (irq !== 1'b1) begin nfail++; $display("FAIL match_irq_timeout got=%b exp=1", irq); end
    rd(8'h00, v);
    nchecks++;
    if (v !== 32'd6) begin nfail++; $display("FAIL match_count_at_irq got=%0d exp=6", v); end
    cycle(0, 8'h00, 32'd0);
    rd(8'h00, v);
    nchecks++;
    if (v !== 32'd7) begin nfail++; $display("FAIL match_continue got=%0d exp=7", v); end
    cycle(1, 8'h0C, 32'h1);
    nchecks++;
    if (irq !== 1'b0) begin nfail++; $display("FAIL match_w1c_irq got=%b exp=0", irq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    int rises;
    logic prev;
    do_reset();
    cycle(1, 8'h04, 32'd3);
    cycle(1, 8'h08, 32'h7);
    rises = 0; prev = 0;
    for (int i = 0; i < 16; i++) begin
      rd(8'h00, v);
      nchecks++;
      if (v !== m_count || v > 32'd3) begin
        nfail++; $display("FAIL autoreload_count got=%0d exp=%0d", v, m_count);
      end
      nchecks++;
      if (irq !== (m_pend & m_ie)) begin nfail++; $display("FAIL autoreload_irq got=%b exp=%b", irq, m_pend & m_ie); end
      if (v == 32'd3) cycle(1, 8'h0C, 32'h1);
      else cycle(0, 8'h00, 32'd0);
    end
    // wrap without a flag
    do_reset();
    cycle(1, 8'h00, 32'hFFFF_FFFF);
    cycle(1, 8'h04, 32'd10);
    cycle(1, 8'h08, 32'h1);
    cycle(0, 8'h00, 32'd0);
    rd(8'h00, v);
    nchecks++;
    if (v !== 32'd0) begin nfail++; $display("FAIL wrap_count got=%h exp=0", v); end
    rd(8'h0C, v);
    nchecks++;
    if (v !== 32'd0) begin nfail++; $display("FAIL wrap_pending got=%h exp=0", v); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    int guard;
    do_reset();
    cycle(1, 8'h04, 32'd5);
    cycle(1, 8'h08, 32'h1);
    guard = 0;
    while (m_count != 32'd5 && guard < 30) begin cycle(0, 8'h00, 32'd0); guard++; end
    cycle(1, 8'h00, 32'd100);
    rd(8'h00, v);
    nchecks++;
    if (v !== 32'd100) begin nfail++; $display("FAIL coll_count_write got=%0d exp=100", v); end
    rd(8'h0C, v);
    nchecks++;
    if (v !== 32'd0) begin nfail++; $display("FAIL coll_pending_unchanged got=%0d exp=0", v); end
    cycle(1, 8'h04, 32'd103);
    guard = 0;
    while (m_count != 32'd103 && guard < 30) begin cycle(0, 8'h00, 32'd0); guard++; end
    cycle(1, 8'h0C, 32'h1);
    rd(8'h0C, v);
    nchecks++;
    if (v !== 32'd1) begin nfail++; $display("FAIL coll_w1c_vs_set got=%0d exp=1", v); end
    rd(8'h00, v);
    nchecks++;
    if (v !== 32'd104) begin nfail++; $display("FAIL coll_count_after got=%0d exp=104", v); end
  endtask

  task automatic test_enable_hold();
    logic [31:0] v;
    int guard;
    do_reset();
    cycle(1, 8'h08, 32'h1);
    guard = 0;
    while (m_count != 32'd6 && guard < 30) begin cycle(0, 8'h00, 32'd0); guard++; end
    cycle(1, 8'h08, 32'h0);
    for (int i = 0; i < 10; i++) begin
      rd(8'h00, v);
      nchecks++;
      if (v !== 32'd7) begin nfail++; $display("FAIL hold_count cyc=%0d got=%0d exp=7", i, v); end
      cycle(0, 8'h00, 32'd0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd0; exp_v[1] = 32'hFFFF_FFFF; exp_v[2] = 32'd0; exp_v[3] = 32'd0;
    do_reset();
    cycle(1, 8'h04, 32'd2);
    cycle(1, 8'h08, 32'h5);
    repeat (6) cycle(0, 8'h00, 32'd0);
    nchecks++;
    if (irq !== 1'b1) begin nfail++; $display("FAIL midrst_pre_irq got=%b exp=1", irq); end
    rst_n = 0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(8'(i * 4), v);
      nchecks++;
      if (v !== exp_v[i]) begin
        nfail++; $display("FAIL midrst_reg%0d got=%h exp=%h", i, v, exp_v[i]);
      end
    end
    nchecks++;
    if (irq !== 1'b0) begin nfail++; $display("FAIL midrst_irq got=%b exp=0", irq); end
    @(negedge clk_bus);
    rst_n = 1;
    @(posedge clk_bus);
    #1;
  endtask

  task automatic test_prescaler();
    logic [31:0] v;
    do_reset();
    cycle(1, 8'h10, 32'd3);
    rd(8'h10, v);
`ifdef TIMER_CMP_PRESCALER_EN
    nchecks++;
    if (v !== 32'd3) begin nfail++; $display("FAIL presc_read got=%0d exp=3", v); end
    cycle(1, 8'h08, 32'h1);
    for (int i = 0; i < 16; i++) begin
      rd(8'h00, v);
      nchecks++;
      if (v !== m_count) begin nfail++; $display("FAIL presc_count got=%0d exp=%0d", v, m_count); end
      cycle(0, 8'h00, 32'd0);
    end
    rd(8'h00, v);
    nchecks++;
    if (v !== 32'd4) begin nfail++; $display("FAIL presc_rate got=%0d exp=4", v); end
`else
    nchecks++;
    if (v !== 32'd0) begin nfail++; $display("FAIL presc_absent got=%0d exp=0", v); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] v, d;
    logic [7:0]  a;
    bit          we;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      we = 1;
      case ($urandom_range(0, 9))
        0:       begin a = 8'h00; d = $urandom_range(0, 12); end
        1:       begin a = 8'h04; d = $urandom_range(0, 12); end
        2:       begin a = 8'h08; d = $urandom; end
        3:       begin a = 8'h0C; d = $urandom; end
        4:       begin a = 8'h10; d = $urandom_range(0, 3); end
        5:       begin a = 8'($urandom_range(8'h14, 8'hFF)); d = $urandom_range(0, 12); end
        default: begin we = 0; a = 8'($urandom_range(0, 4) * 4); d = $urandom; end
      endcase
      a = a | 8'($urandom_range(0, 3));
      // read in the same cycle as the write returns the old value
      bus_write = we; bus_address = a; bus_data_i = d; bus_read = 1;
      #1;
      nchecks++;
      if (bus_data_o !== m_read(a)) begin
        nfail++; $display("FAIL rand_rdw addr=%h got=%h exp=%h", a, bus_data_o, m_read(a));
      end
      bus_read = 0;
      @(posedge clk_bus);
      model_step(we, a, d);
      #1;
      bus_write = 0;
      for (int i = 0; i < 5; i++) begin
        rd(8'(i * 4), v);
        nchecks++;
        if (v !== m_read(8'(i * 4))) begin
          nfail++; $display("FAIL rand_reg%0d it=%0d got=%h exp=%h", i, n, v, m_read(8'(i * 4)));
        end
      end
      nchecks++;
      if (irq !== (m_pend & m_ie)) begin
        nfail++; $display("FAIL rand_irq it=%0d got=%b exp=%b", n, irq, m_pend & m_ie);
      end
      #1;
      nchecks++;
      if (bus_data_o !== 32'd0) begin
        nfail++; $display("FAIL rand_idle_data got=%h exp=0", bus_data_o);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_match();
    test_autoreload();
    test_collision();
    test_enable_hold();
    test_reset_mid();
    test_prescaler();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
